maxpool8_pack: RTL and testbench
================================

// Module: maxpool8_pack
// PURPOSE
// - Sits directly downstream of the 8-lane ReLU stage. Takes its 8 unsigned 8-bit activations per cycle
//   and performs 1-D max pooling over POOL_LEN consecutive valid samples per lane (ECG time axis).
// - Packs the 8 pooled bytes into one 64-bit word and writes it to feature-map SRAM.
// - The write address auto-increments and restarts at 0 for every layer.
// PARAMETERS
// - LANES     8    parallel channels; must match the ReLU stage
// - DW        8    activation width, unsigned
// - POOL_LEN  2    pooling window length in valid samples; legal range 1..8
// - AW        10   feature-map SRAM word-address width
// PORTS
// - clk_cal       in   1         compute clock; all logic on rising edge
// - rst_cal       in   1         synchronous, active-high reset
// - layer_start   in   1         1-cycle pulse. Clears address, window and error; latches pool_en.
// - pool_en       in   1         1 = max-pool over POOL_LEN; 0 = bypass, every sample written
// - flush         in   1         1-cycle pulse at layer end; emits any partial window
// - pool_din      in   LANES*DW  lane i in bits [i*DW +: DW]; driven by the ReLU outputs
// - pool_din_vld  in   LANES     per-lane valid from the ReLU outputs
// - fm_wr_en      out  1         SRAM write strobe, 1 cycle per word
// - fm_wr_addr    out  AW        SRAM word address
// - fm_wr_data    out  LANES*DW  pooled word; lane i in bits [i*DW +: DW]
// - fm_wr_cnt     out  AW+1      words written since layer_start
// - err_vld_mis   out  1         sticky; set when pool_din_vld is neither all-0 nor all-1
// BEHAVIOUR
// - Reset: all outputs 0; win_cnt=0; max regs=0; pool_en_q=0.
// - Priority in a single cycle: rst_cal > layer_start > sample/flush. On layer_start, the same-cycle
//   sample and flush are dropped. Address, count, window and error are cleared; pool_en_q <= pool_en.
// - Accept: a sample is accepted when pool_din_vld == all-1. Mixed vld: nothing is accepted, win_cnt is
//   unchanged, and err_vld_mis <= 1 until the next layer_start or reset.
// - Window: on accept, if win_cnt==0 then max_i <= din_i, else max_i <= max(max_i, din_i).
//   Comparison is unsigned DW-bit; no width growth.
// - Emit: the cycle after the sample that completes the window (win_cnt==POOL_LEN-1 at accept):
//   fm_wr_en=1 and fm_wr_data = max including that sample. win_cnt then returns to 0.
//   Latency is exactly 1 cycle from the completing sample. POOL_LEN=1 behaves like bypass.
// - Bypass (pool_en_q=0): every accepted sample is written 1 cycle later, unchanged.
// - Flush: if win_cnt!=0, the partial max is emitted next cycle and win_cnt <= 0. If win_cnt==0, no write.
//   Flush in the same cycle as an accepted sample: the sample is folded in first, then exactly one write
//   is emitted. This holds even when that sample also completes the window.
// - Address: fm_wr_addr holds the address of the current write. It increments by 1 after each write and
//   wraps 2^AW-1 -> 0 silently. fm_wr_cnt saturates at 2^AW.
// - Outputs are registered. fm_wr_data/fm_wr_addr hold their last value when fm_wr_en=0.
// - Back-to-back completing windows (e.g. POOL_LEN=1) give a write every cycle; no stall and no backpressure.
// - Reset mid-window discards the partial max; no write is produced.
// STRUCTURE
// - Shared package/defines: DW(byte_width=8), halfword_width=16, LANES=8, FM_WORD_W=LANES*DW, AW default.
// - Sub-module pool_lane: one lane's max register plus compare (inputs: clk_cal, rst_cal, clr, acc, first,
//   din; output: max). Instantiate it LANES times.
// - Top level holds win_cnt, pool_en_q, emit logic, address/count counters and the vld-mismatch check.
// TESTING
// - POOL_LEN=2, pool_en=1, lane0 samples 5,9,3,2 (vld all-1) -> writes lane0=9 @addr0, lane0=3 @addr1;
//   each write 1 cycle after the 2nd sample.
// - pool_en=0, 3 samples 0x10,0x20,0x30 on all lanes -> 3 consecutive writes, addr 0,1,2, data replicated
//   per lane.
// - POOL_LEN=2, single sample 0x7F then flush -> one write 0x7F; a second flush -> no write.
// - Sample completing the window plus flush in the same cycle -> exactly one write; fm_wr_cnt +1.
// - pool_din_vld=8'h0F for one cycle -> err_vld_mis=1, no window advance; layer_start -> err cleared,
//   addr=0.
// - AW=2, 5 bypass samples -> addresses 0,1,2,3,0; fm_wr_cnt=4 (saturated).

Source files
------------

// File: rtl/maxpool8_pack_pkg.sv
// Shared widths and defaults for the 8-lane max-pool / feature-map packer.
package maxpool8_pack_pkg;
    localparam int BYTE_W           = 8;
    localparam int NUM_LANES        = 8;
    localparam int FM_WORD_W        = NUM_LANES * BYTE_W;
    localparam int AW_DEFAULT       = 10;
    localparam int POOL_LEN_DEFAULT = 2;
endpackage

// File: rtl/maxpool8_pack_pool_lane.sv
// One lane's running-max register; nxt is the value max takes on an accepted sample.
module maxpool8_pack_pool_lane #(
    parameter int DW = 8
) (
    input  logic          clk_cal,
    input  logic          rst_cal,
    input  logic          clr,
    input  logic          acc,
    input  logic          first,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] max,
    output logic [DW-1:0] nxt
);

    // The first sample of a window replaces the stale max instead of comparing against it.
    always_comb begin
        nxt = (first || (din > max)) ? din : max;
    end

    always_ff @(posedge clk_cal) begin
        if (rst_cal || clr) begin
            max <= '0;
        end else if (acc) begin
            max <= nxt;
        end
    end

endmodule

// File: rtl/maxpool8_pack.sv
// 1-D max pooling over POOL_LEN valid samples per lane, packed into 64-bit feature-map SRAM writes.
module maxpool8_pack
    import maxpool8_pack_pkg::*;
#(
    parameter int LANES    = NUM_LANES,
    parameter int DW       = BYTE_W,
    parameter int POOL_LEN = POOL_LEN_DEFAULT,
    parameter int AW       = AW_DEFAULT
) (
    input  logic                clk_cal,
    input  logic                rst_cal,
    input  logic                layer_start,
    input  logic                pool_en,
    input  logic                flush,
    input  logic [LANES*DW-1:0] pool_din,
    input  logic [LANES-1:0]    pool_din_vld,
    output logic                fm_wr_en,
    output logic [AW-1:0]       fm_wr_addr,
    output logic [LANES*DW-1:0] fm_wr_data,
    output logic [AW:0]         fm_wr_cnt,
    output logic                err_vld_mis
);

    logic                pool_en_q;
    logic [3:0]          win_cnt;
    logic [3:0]          len_eff;
    logic [AW-1:0]       next_addr;
    logic                acc;
    logic                mixed;
    logic                first;
    logic                complete;
    logic                emit;
    logic [LANES*DW-1:0] max_all;
    logic [LANES*DW-1:0] nxt_all;
    logic [LANES*DW-1:0] data_nxt;

    // layer_start wins over everything else presented in the same cycle.
    always_comb begin
        len_eff  = pool_en_q ? 4'(POOL_LEN) : 4'd1;
        acc      = !layer_start && (&pool_din_vld);
        mixed    = !layer_start && (|pool_din_vld) && !(&pool_din_vld);
        first    = (win_cnt == 4'd0);
        complete = acc && (win_cnt == (len_eff - 4'd1));
        emit     = complete || (!layer_start && flush && (acc || (win_cnt != 4'd0)));
        data_nxt = acc ? nxt_all : max_all;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        maxpool8_pack_pool_lane #(.DW(DW)) u_lane (
            .clk_cal (clk_cal),
            .rst_cal (rst_cal),
            .clr     (layer_start),
            .acc     (acc),
            .first   (first),
            .din     (pool_din[i*DW +: DW]),
            .max     (max_all[i*DW +: DW]),
            .nxt     (nxt_all[i*DW +: DW])
        );
    end

    always_ff @(posedge clk_cal) begin
        if (rst_cal) begin
            pool_en_q   <= 1'b0;
            win_cnt     <= '0;
            next_addr   <= '0;
            fm_wr_en    <= 1'b0;
            fm_wr_addr  <= '0;
            fm_wr_data  <= '0;
            fm_wr_cnt   <= '0;
            err_vld_mis <= 1'b0;
        end else begin
            fm_wr_en <= emit;
            if (layer_start) begin
                pool_en_q   <= pool_en;
                win_cnt     <= '0;
                next_addr   <= '0;
                fm_wr_addr  <= '0;
                fm_wr_cnt   <= '0;
                err_vld_mis <= 1'b0;
            end else begin
                if (mixed) begin
                    err_vld_mis <= 1'b1;
                end
                if (emit) begin
                    win_cnt    <= '0;
                    fm_wr_data <= data_nxt;
                    fm_wr_addr <= next_addr;
                    next_addr  <= next_addr + 1'b1;
                    // MSB set means the count has reached 2^AW and stays there.
                    if (!fm_wr_cnt[AW]) begin
                        fm_wr_cnt <= fm_wr_cnt + 1'b1;
                    end
                end else if (acc) begin
                    win_cnt <= win_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool8_pack.sv
// Bench for maxpool8_pack: directed scenarios plus random traffic against a sample-level model.
module tb_maxpool8_pack;

    localparam int POOL_LEN = 2;

    logic        clk_cal = 1'b0;
    logic        rst_cal;
    logic        layer_start;
    logic        pool_en;
    logic        flush;
    logic [63:0] pool_din;
    logic [7:0]  pool_din_vld;

    logic        en_a, err_a, en_b, err_b;
    logic [9:0]  addr_a;
    logic [10:0] cnt_a;
    logic [63:0] data_a, data_b;
    logic [1:0]  addr_b;
    logic [2:0]  cnt_b;

    always #5 clk_cal = ~clk_cal;

    maxpool8_pack #(.POOL_LEN(POOL_LEN), .AW(10)) u_dut_a (
        .clk_cal(clk_cal), .rst_cal(rst_cal), .layer_start(layer_start), .pool_en(pool_en),
        .flush(flush), .pool_din(pool_din), .pool_din_vld(pool_din_vld),
        .fm_wr_en(en_a), .fm_wr_addr(addr_a), .fm_wr_data(data_a), .fm_wr_cnt(cnt_a),
        .err_vld_mis(err_a)
    );

    maxpool8_pack #(.POOL_LEN(POOL_LEN), .AW(2)) u_dut_b (
        .clk_cal(clk_cal), .rst_cal(rst_cal), .layer_start(layer_start), .pool_en(pool_en),
        .flush(flush), .pool_din(pool_din), .pool_din_vld(pool_din_vld),
        .fm_wr_en(en_b), .fm_wr_addr(addr_b), .fm_wr_data(data_b), .fm_wr_cnt(cnt_b),
        .err_vld_mis(err_b)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample-level reference: window contents, written-word count, sticky error.
    logic [63:0] exp_q[$];
    logic        m_pool_en = 1'b0;
    int          m_win = 0;
    logic [7:0]  m_max[8];
    logic        m_en = 1'b0;
    logic [63:0] m_data = '0;
    int          m_addr = 0;
    int          m_writes = 0;
    logic        m_err = 1'b0;
    logic        m_acc;
    int          m_len;

    always @(posedge clk_cal) begin
        if (rst_cal) begin
            m_pool_en = 1'b0; m_win = 0; m_en = 1'b0; m_data = '0;
            m_addr = 0; m_writes = 0; m_err = 1'b0;
        end else if (layer_start) begin
            m_pool_en = pool_en; m_win = 0; m_en = 1'b0;
            m_addr = 0; m_writes = 0; m_err = 1'b0;
        end else begin
            m_acc = (pool_din_vld == 8'hFF);
            if (pool_din_vld != 8'h00 && !m_acc) m_err = 1'b1;
            m_len = m_pool_en ? POOL_LEN : 1;
            if (m_acc) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_win == 0 || pool_din[i*8 +: 8] > m_max[i]) m_max[i] = pool_din[i*8 +: 8];
                end
                m_win++;
            end
            m_en = (m_acc && m_win == m_len) || (flush && m_win != 0);
            if (m_en) begin
                for (int i = 0; i < 8; i++) m_data[i*8 +: 8] = m_max[i];
                exp_q.push_back(m_data);
                m_addr = m_writes;
                m_writes++;
                m_win = 0;
            end
        end
    end

    always @(negedge clk_cal) begin
        if (chk_on) begin
            chk("wr_en_a", en_a, m_en);
            chk("wr_en_b", en_b, m_en);
            if (m_en) begin
                if (exp_q.size() == 0) chk("queue_empty", 64'd1, 64'd0);
                else chk("data_a", data_a, exp_q.pop_front());
            end
            chk("data_b", data_b, m_data);
            chk("addr_a", addr_a, 64'(m_addr % 1024));
            chk("addr_b", addr_b, 64'(m_addr % 4));
            chk("cnt_a", cnt_a, 64'((m_writes > 1024) ? 1024 : m_writes));
            chk("cnt_b", cnt_b, 64'((m_writes > 4) ? 4 : m_writes));
            chk("err_a", err_a, m_err);
            chk("err_b", err_b, m_err);
        end
    end

    task automatic drive(input logic ls, input logic pe, input logic fl,
                         input logic [63:0] d, input logic [7:0] v);
        @(negedge clk_cal);
        layer_start = ls; pool_en = pe; flush = fl; pool_din = d; pool_din_vld = v;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
        #1;
    endtask

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    initial begin
        rst_cal = 1'b1; layer_start = 1'b0; pool_en = 1'b0; flush = 1'b0;
        pool_din = '0; pool_din_vld = '0;
        @(negedge clk_cal);
        chk_on = 1'b1;
        @(negedge clk_cal);
        #1;
        chk("rst_en", en_a, 64'd0);
        chk("rst_data", data_a, 64'd0);
        chk("rst_addr", addr_a, 64'd0);
        chk("rst_cnt", cnt_a, 64'd0);
        chk("rst_err", err_a, 64'd0);
        @(negedge clk_cal);
        rst_cal = 1'b0;

        // Pooling, lane 0 carries 5,9,3,2
        drive(1'b1, 1'b1, 1'b0, 64'd0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 64'h05, 8'hFF);
        idle();
        chk("pool_no_early_write", en_a, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 64'h09, 8'hFF);
        idle();
        chk("pool_w0_en", en_a, 64'd1);
        chk("pool_w0_data", data_a, 64'h09);
        chk("pool_w0_addr", addr_a, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 64'h03, 8'hFF);
        drive(1'b0, 1'b0, 1'b0, 64'h02, 8'hFF);
        idle();
        chk("pool_w1_data", data_a, 64'h03);
        chk("pool_w1_addr", addr_a, 64'd1);
        chk("pool_w1_cnt", cnt_a, 64'd2);

        // Bypass
        drive(1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, rep(8'h10), 8'hFF);
        drive(1'b0, 1'b0, 1'b0, rep(8'h20), 8'hFF);
        drive(1'b0, 1'b0, 1'b0, rep(8'h30), 8'hFF);
        idle();
        chk("byp_data", data_a, 64'h3030303030303030);
        chk("byp_addr", addr_a, 64'd2);
        chk("byp_cnt", cnt_a, 64'd3);

        // Partial window flush, then an empty flush
        drive(1'b1, 1'b1, 1'b0, 64'd0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, rep(8'h7F), 8'hFF);
        drive(1'b0, 1'b0, 1'b1, 64'd0, 8'h00);
        idle();
        chk("flush_en", en_a, 64'd1);
        chk("flush_data", data_a, 64'h7F7F7F7F7F7F7F7F);
        drive(1'b0, 1'b0, 1'b1, 64'd0, 8'h00);
        idle();
        chk("flush_empty_en", en_a, 64'd0);

        // Completing sample together with flush
        drive(1'b1, 1'b1, 1'b0, 64'd0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, rep(8'h11), 8'hFF);
        drive(1'b0, 1'b0, 1'b1, rep(8'h22), 8'hFF);
        idle();
        chk("cf_en", en_a, 64'd1);
        chk("cf_data", data_a, 64'h2222222222222222);
        chk("cf_cnt", cnt_a, 64'd1);
        idle();
        chk("cf_single", en_a, 64'd0);

        // Mixed valid
        drive(1'b1, 1'b1, 1'b0, 64'd0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, rep(8'h40), 8'h0F);
        idle();
        chk("mis_err", err_a, 64'd1);
        drive(1'b0, 1'b0, 1'b0, rep(8'h01), 8'hFF);
        drive(1'b0, 1'b0, 1'b0, rep(8'h02), 8'hFF);
        idle();
        chk("mis_data", data_a, 64'h0202020202020202);
        drive(1'b0, 1'b0, 1'b0, rep(8'h03), 8'hFF);
        drive(1'b0, 1'b0, 1'b0, rep(8'h04), 8'hFF);
        idle();
        chk("mis_addr1", addr_a, 64'd1);
        drive(1'b1, 1'b1, 1'b0, 64'd0, 8'h00);
        idle();
        chk("ls_err_clr", err_a, 64'd0);
        chk("ls_addr_clr", addr_a, 64'd0);
        chk("ls_cnt_clr", cnt_a, 64'd0);

        // Address wrap on the AW=2 instance
        drive(1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        for (int i = 1; i <= 5; i++) drive(1'b0, 1'b0, 1'b0, rep(8'(i)), 8'hFF);
        idle();
        chk("wrap_addr_b", addr_b, 64'd0);
        chk("wrap_cnt_b", cnt_b, 64'd4);
        chk("wrap_addr_a", addr_a, 64'd4);
        chk("wrap_cnt_a", cnt_a, 64'd5);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [7:0] v;
            r = $urandom_range(0, 99);
            if (r < 70) v = 8'hFF;
            else if (r < 95) v = 8'h00;
            else v = 8'($urandom_range(1, 254));
            @(negedge clk_cal);
            rst_cal      = ($urandom_range(0, 99) < 1);
            layer_start  = ($urandom_range(0, 99) < 3);
            pool_en      = 1'($urandom_range(0, 1));
            flush        = ($urandom_range(0, 99) < 10);
            pool_din     = {$urandom, $urandom};
            pool_din_vld = v;
        end
        @(negedge clk_cal);
        rst_cal = 1'b0;
        idle();
        idle();
        chk("queue_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
